// File: rtl/data_mem_access.sv
// data_mem_access
//   Bridges execute-stage load/store requests to a synchronous word-wide data
//   SRAM with byte write enables. It stalls the pipeline across the SRAM read
//   latency and returns aligned, sign- or zero-extended load data.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   req_en        : request valid
//   req_wen       : 1 = store, 0 = load
//   req_size      : 00 byte, 01 half, 10 word, 11 illegal
//   req_signed    : loads only, sign-extend when set
//   req_addr      : byte address
//   req_wdata     : right-justified store data
//   stall         : combinational pipeline hold
//   load_valid    : one-cycle pulse qualifying load_data
//   load_data     : extended load result
//   access_err    : one-cycle pulse for a misaligned or illegal-size request
//   mem_en        : SRAM read strobe
//   mem_we        : SRAM byte write enables (bit i = byte lane i)
//   mem_addr      : SRAM word address
//   mem_wdata     : SRAM write data
//   mem_rdata     : SRAM read data, valid READ_LATENCY cycles after mem_en
module data_mem_access #(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned READ_LATENCY = 1   // legal range 1..4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_en,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              load_valid,
  output logic [31:0]       load_data,
  output logic              access_err,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_WAIT  = 2'd2,
    RD_DONE  = 2'd3
  } state_t;

  state_t r_state, w_next;

  logic [1:0]        r_off;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [1:0]        r_cnt;

  logic              r_mem_en;
  logic [3:0]        r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_load_valid;
  logic [31:0]       r_load_data;
  logic              r_access_err;

  logic              w_legal;
  logic              w_load_ok;
  logic              w_store_ok;
  logic              w_err;
  logic              w_last;
  logic [3:0]        w_we;
  logic [31:0]       w_wdata;
  logic [31:0]       w_shift;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_ext;
  logic              w_unused;

  // Only the word-address slice of req_addr reaches the SRAM.
  assign w_unused = &{1'b0, req_addr};

  always_comb begin
    w_legal = 1'b0;
    unique case (req_size)
      2'b00:   w_legal = 1'b1;
      2'b01:   w_legal = ~req_addr[0];
      2'b10:   w_legal = (req_addr[1:0] == 2'b00);
      default: w_legal = 1'b0;
    endcase
  end

  assign w_load_ok  = (r_state == IDLE) && req_en && !req_wen && w_legal;
  assign w_store_ok = (r_state == IDLE) && req_en &&  req_wen && w_legal;
  assign w_err      = (r_state == IDLE) && req_en && !w_legal;
  assign w_last     = (r_cnt == 2'(READ_LATENCY - 1));

  assign stall = (r_state == RD_ISSUE) || (r_state == RD_WAIT) || w_load_ok;

  // Store lane steering: data is replicated across lanes, enables pick the lane.
  always_comb begin
    w_we    = '0;
    w_wdata = '0;
    unique case (req_size)
      2'b00: begin
        w_we    = 4'b0001 << req_addr[1:0];
        w_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_we    = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        w_we    = 4'b1111;
        w_wdata = req_wdata;
      end
      default: begin
        w_we    = '0;
        w_wdata = '0;
      end
    endcase
  end

  // Load extraction uses the offset/size/signedness captured at acceptance.
  always_comb begin
    w_shift = mem_rdata >> {r_off, 3'b000};
    w_byte  = w_shift[7:0];
    w_half  = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    w_ext   = mem_rdata;
    unique case (r_size)
      2'b00:   w_ext = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_ext = {{16{r_signed & w_half[15]}}, w_half};
      default: w_ext = mem_rdata;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     if (w_load_ok) w_next = RD_ISSUE;
      RD_ISSUE: w_next = RD_WAIT;
      RD_WAIT:  if (w_last) w_next = RD_DONE;
      RD_DONE:  w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // All memory-side and result outputs are registered; the issue cycle's
  // strobes are computed from the IDLE-cycle request so they land in RD_ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_off        <= '0;
      r_size       <= '0;
      r_signed     <= 1'b0;
      r_cnt        <= '0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_load_valid <= 1'b0;
      r_load_data  <= '0;
      r_access_err <= 1'b0;
    end else begin
      r_mem_en     <= w_load_ok;
      r_mem_we     <= w_store_ok ? w_we : 4'b0000;
      r_mem_wdata  <= w_store_ok ? w_wdata : 32'h0;
      r_mem_addr   <= (w_load_ok || w_store_ok) ? req_addr[ADDR_W+1:2] : '0;
      r_access_err <= w_err;
      r_load_valid <= (r_state == RD_WAIT) && w_last;
      r_load_data  <= ((r_state == RD_WAIT) && w_last) ? w_ext : 32'h0;

      if (w_load_ok) begin
        r_off    <= req_addr[1:0];
        r_size   <= req_size;
        r_signed <= req_signed;
      end

      if (r_state == RD_WAIT) begin
        r_cnt <= r_cnt + 2'd1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign load_valid = r_load_valid;
  assign load_data  = r_load_data;
  assign access_err = r_access_err;

endmodule

// File: tb/tb_data_mem_access.sv
module tb_data_mem_access;

  localparam int unsigned AW = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_en, req_wen, req_signed, sel3;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [31:0] sram_word;

  logic          en1, en3;
  logic          stall1, lv1, err1, men1, stall3, lv3, err3, men3;
  logic [31:0]   ld1, wd1, rd1, ld3, wd3, rd3;
  logic [3:0]    we1, we3;
  logic [AW-1:0] ma1, ma3;
  logic [31:0]   d3a, d3b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign en1 = req_en && !sel3;
  assign en3 = req_en &&  sel3;

  data_mem_access #(.ADDR_W(AW), .READ_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_en(en1), .req_wen(req_wen), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall1), .load_valid(lv1), .load_data(ld1), .access_err(err1),
    .mem_en(men1), .mem_we(we1), .mem_addr(ma1), .mem_wdata(wd1), .mem_rdata(rd1)
  );

  data_mem_access #(.ADDR_W(AW), .READ_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_en(en3), .req_wen(req_wen), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall3), .load_valid(lv3), .load_data(ld3), .access_err(err3),
    .mem_en(men3), .mem_we(we3), .mem_addr(ma3), .mem_wdata(wd3), .mem_rdata(rd3)
  );

  // SRAM models: data is only meaningful exactly READ_LATENCY cycles after
  // mem_en; every other cycle returns a poison pattern.
  always @(posedge clk) begin
    rd1 <= men1 ? sram_word : 32'hBAD0_BAD0;
    d3a <= men3 ? sram_word : 32'hBAD0_BAD0;
    d3b <= d3a;
    rd3 <= d3b;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    req_en = 1'b0; req_wen = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
  endtask

  task automatic drive(input logic wen, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_en = 1'b1; req_wen = wen; req_size = sz; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
  endtask

  // Latency-1 load on u_dut1: request in cycle 0, result in cycle 3.
  task automatic load1(input string tag, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] word,
                       input logic [31:0] exp);
    sram_word = word;
    drive(1'b0, sz, sgn, addr, 32'h0);
    #1 check({tag, " stall c0"}, 32'(stall1), 32'd1);
    tick();
    check({tag, " stall c1"}, 32'(stall1), 32'd1);
    check({tag, " mem_en c1"}, 32'(men1), 32'd1);
    check({tag, " mem_addr c1"}, 32'(ma1), 32'(addr[AW+1:2]));
    tick();
    check({tag, " stall c2"}, 32'(stall1), 32'd1);
    check({tag, " mem_en c2"}, 32'(men1), 32'd0);
    check({tag, " lv c2"}, 32'(lv1), 32'd0);
    tick();
    check({tag, " stall c3"}, 32'(stall1), 32'd0);
    check({tag, " lv c3"}, 32'(lv1), 32'd1);
    check({tag, " data c3"}, ld1, exp);
    idle_in();
    tick();
    check({tag, " lv c4"}, 32'(lv1), 32'd0);
    check({tag, " mem_en c4"}, 32'(men1), 32'd0);
  endtask

  initial begin
    idle_in();
    sel3 = 1'b0;
    sram_word = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst stall", 32'(stall1), 32'd0);
    check("rst mem_en", 32'(men1), 32'd0);
    check("rst mem_we", 32'(we1), 32'd0);
    check("rst lv", 32'(lv1), 32'd0);
    check("rst err", 32'(err1), 32'd0);
    check("rst ld", ld1, 32'd0);
    tick();

    // sb 0xA5 -> 0x6
    drive(1'b1, 2'b00, 1'b0, 32'h6, 32'h0000_00A5);
    #1 check("sb stall", 32'(stall1), 32'd0);
    tick();
    idle_in();
    check("sb we", 32'(we1), 32'h4);
    check("sb addr", 32'(ma1), 32'd1);
    check("sb wdata", wd1, 32'hA5A5_A5A5);
    check("sb mem_en", 32'(men1), 32'd0);
    tick();
    check("sb we off", 32'(we1), 32'h0);

    // sh 0x1234 -> 0x0A then sw 0xDEADBEEF -> 0x10, back to back
    drive(1'b1, 2'b01, 1'b0, 32'h0A, 32'h0000_1234);
    #1 check("sh stall", 32'(stall1), 32'd0);
    tick();
    drive(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    #1;
    check("sh we", 32'(we1), 32'hC);
    check("sh addr", 32'(ma1), 32'd2);
    check("sh wdata", wd1, 32'h1234_1234);
    check("sw stall", 32'(stall1), 32'd0);
    tick();
    idle_in();
    check("sw we", 32'(we1), 32'hF);
    check("sw addr", 32'(ma1), 32'd4);
    check("sw wdata", wd1, 32'hDEAD_BEEF);
    tick();
    check("sw we off", 32'(we1), 32'h0);

    // loads with READ_LATENCY = 1
    load1("lw", 2'b10, 1'b0, 32'h10, 32'hCAFE_F00D, 32'hCAFE_F00D);
    load1("lb", 2'b00, 1'b1, 32'h13, 32'h80FF_0000, 32'hFFFF_FF80);
    load1("lbu", 2'b00, 1'b0, 32'h13, 32'h80FF_0000, 32'h0000_0080);
    load1("lhu", 2'b01, 1'b0, 32'h12, 32'h80FF_0000, 32'h0000_80FF);
    load1("lh", 2'b01, 1'b1, 32'h12, 32'h80FF_0000, 32'hFFFF_80FF);
    load1("lb1", 2'b00, 1'b1, 32'h11, 32'h1234_9A78, 32'hFFFF_FF9A);
    load1("lw sgn", 2'b10, 1'b1, 32'h20, 32'h8000_0001, 32'h8000_0001);

    // misaligned lw
    drive(1'b0, 2'b10, 1'b0, 32'h2, 32'h0);
    #1 check("mis stall", 32'(stall1), 32'd0);
    tick();
    idle_in();
    check("mis err", 32'(err1), 32'd1);
    check("mis mem_en", 32'(men1), 32'd0);
    check("mis we", 32'(we1), 32'd0);
    tick();
    check("mis err off", 32'(err1), 32'd0);

    // illegal size store, misaligned sh
    drive(1'b1, 2'b11, 1'b0, 32'h4, 32'hFFFF_FFFF);
    tick();
    drive(1'b1, 2'b01, 1'b0, 32'h5, 32'hFFFF_FFFF);
    #1;
    check("sz11 err", 32'(err1), 32'd1);
    check("sz11 we", 32'(we1), 32'd0);
    tick();
    idle_in();
    check("sh odd err", 32'(err1), 32'd1);
    check("sh odd we", 32'(we1), 32'd0);
    tick();

    // READ_LATENCY = 3 load: stall in cycles 0..4, result in cycle 5
    sel3 = 1'b1;
    sram_word = 32'h1122_3344;
    drive(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    #1 check("L3 stall c0", 32'(stall3), 32'd1);
    tick();
    check("L3 mem_en c1", 32'(men3), 32'd1);
    check("L3 addr c1", 32'(ma3), 32'd16);
    tick();
    tick();
    tick();
    check("L3 stall c4", 32'(stall3), 32'd1);
    check("L3 lv c4", 32'(lv3), 32'd0);
    tick();
    check("L3 stall c5", 32'(stall3), 32'd0);
    check("L3 lv c5", 32'(lv3), 32'd1);
    check("L3 data c5", ld3, 32'h1122_3344);
    idle_in();
    tick();

    // reset during RD_WAIT (cycle 2) of a latency-3 load
    drive(1'b0, 2'b00, 1'b1, 32'h43, 32'h0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_in();
    #1;
    check("rstmid stall", 32'(stall3), 32'd0);
    check("rstmid lv", 32'(lv3), 32'd0);
    check("rstmid ld", ld3, 32'd0);
    check("rstmid mem_en", 32'(men3), 32'd0);
    check("rstmid we", 32'(we3), 32'd0);
    check("rstmid err", 32'(err3), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rstmid no lv", 32'(lv3), 32'd0);
      check("rstmid idle", 32'(stall3), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
